// File: rtl/lcd_peripheral.sv
// rtl/lcd_peripheral.sv - HD44780 character LCD driver with 4-entry write FIFO
module lcd_peripheral #(
    parameter int E_PULSE   = 12,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 80000,
    parameter int INIT_WAIT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    // A wait of W cycles ends when the counter reaches W-1; W of 0 or 1 is one cycle.
    function automatic int lastof(input int w);
        return (w <= 1) ? 0 : w - 1;
    endfunction

    localparam int MAX_A   = (E_PULSE > CMD_WAIT) ? E_PULSE : CMD_WAIT;
    localparam int MAX_B   = (CLR_WAIT > INIT_WAIT) ? CLR_WAIT : INIT_WAIT;
    localparam int MAX_W   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (MAX_W < 1) ? 1 : $clog2(MAX_W + 1);
    localparam logic [CW-1:0] E_LAST    = CW'(lastof(E_PULSE));
    localparam logic [CW-1:0] CMD_LAST  = CW'(lastof(CMD_WAIT));
    localparam logic [CW-1:0] CLR_LAST  = CW'(lastof(CLR_WAIT));
    localparam logic [CW-1:0] INIT_LAST = CW'(lastof(INIT_WAIT));

    typedef enum logic [2:0] {
        S_INIT_DELAY,
        S_INIT_SEQ,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic          line_q, line_d;
    logic [3:0]    col_q, col_d;
    logic          wrap_q, wrap_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;

    logic [7:0]    mem [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q;
    logic          push, pop;
    logic [7:0]    head;
    logic [7:0]    init_cmd;
    logic [CW-1:0] settle_last;

    assign full     = (count_q == 3'd4);
    assign push     = wr_en && (!full || pop);
    assign head     = mem[rd_ptr_q];
    assign ready    = (state_q == S_IDLE) && (count_q == 3'd0) && !wrap_q && init_idx_q[2];
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = (state_q == S_PULSE);
    assign lcd_data = data_q;

    // Clear-display needs the long settle; everything else uses the short one.
    assign settle_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    // Power-up command table: 8-bit/2-line, display on, entry increment, clear.
    always_comb begin
        init_cmd = 8'h38;
        case (init_idx_q[1:0])
            2'd0: init_cmd = 8'h38;
            2'd1: init_cmd = 8'h0C;
            2'd2: init_cmd = 8'h06;
            2'd3: init_cmd = 8'h01;
            default: init_cmd = 8'h38;
        endcase
    end

    // FIFO storage; a full FIFO still accepts when a pop frees a slot this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // Transfer engine state register and held bus values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT_DELAY;
            cnt_q      <= '0;
            init_idx_q <= 3'd0;
            line_q     <= 1'b0;
            col_q      <= 4'd0;
            wrap_q     <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            line_q     <= line_d;
            col_q      <= col_d;
            wrap_q     <= wrap_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic: init sequencing, byte translation, cursor tracking, timing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        line_d     = line_q;
        col_d      = col_q;
        wrap_d     = wrap_q;
        rs_d       = rs_q;
        data_d     = data_q;
        pop        = 1'b0;
        case (state_q)
            S_INIT_DELAY: begin
                if (cnt_q == INIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_INIT_SEQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INIT_SEQ: begin
                rs_d       = 1'b0;
                data_d     = init_cmd;
                init_idx_d = init_idx_q + 3'd1;
                state_d    = S_SETUP;
            end
            S_IDLE: begin
                if (wrap_q) begin
                    // Column ran past 15: move to the other line before the next byte.
                    rs_d    = 1'b0;
                    data_d  = line_q ? 8'h80 : 8'hC0;
                    line_d  = ~line_q;
                    col_d   = 4'd0;
                    wrap_d  = 1'b0;
                    state_d = S_SETUP;
                end else if (count_q != 3'd0) begin
                    pop = 1'b1;
                    if (head == 8'h0C) begin
                        rs_d    = 1'b0;
                        data_d  = 8'h01;
                        line_d  = 1'b0;
                        col_d   = 4'd0;
                        state_d = S_SETUP;
                    end else if (head == 8'h0A) begin
                        rs_d    = 1'b0;
                        data_d  = line_q ? 8'h80 : 8'hC0;
                        line_d  = ~line_q;
                        col_d   = 4'd0;
                        state_d = S_SETUP;
                    end else if (head != 8'h00) begin
                        rs_d    = 1'b1;
                        data_d  = head;
                        col_d   = col_q + 4'd1;
                        wrap_d  = (col_q == 4'd15);
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == E_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == settle_last) begin
                    cnt_d   = '0;
                    state_d = init_idx_q[2] ? S_IDLE : S_INIT_SEQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_INIT_DELAY;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_peripheral.sv
// tb/tb_lcd_peripheral.sv - self-checking bench for lcd_peripheral
module tb_lcd_peripheral;
    localparam int P_EP   = 2;
    localparam int P_CMD  = 3;
    localparam int P_CLR  = 5;
    localparam int P_INIT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, ready, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    lcd_peripheral #(
        .E_PULSE(P_EP), .CMD_WAIT(P_CMD), .CLR_WAIT(P_CLR), .INIT_WAIT(P_INIT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .ready(ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected transfers {rs,data} in order, and transfers actually seen.
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int m_line, m_col;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int req);
        checks++;
        if (act < req) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, req);
        end
    endtask

    // Transaction-level model of the display: init commands, then byte translation.
    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        m_line = 0;
        m_col  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0C) begin
            exp_q.push_back(9'h001);
            m_line = 0;
            m_col  = 0;
        end else if (b == 8'h0A) begin
            exp_q.push_back(m_line == 1 ? 9'h080 : 9'h0C0);
            m_line = 1 - m_line;
            m_col  = 0;
        end else if (b != 8'h00) begin
            exp_q.push_back({1'b1, b});
            m_col++;
            if (m_col == 16) begin
                exp_q.push_back(m_line == 1 ? 9'h080 : 9'h0C0);
                m_line = 1 - m_line;
                m_col  = 0;
            end
        end
    endtask

    function automatic int settle_of(input logic [8:0] x);
        return (x == 9'h001) ? P_CLR : P_CMD;
    endfunction

    // Monitor state
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = 9'h0;
    logic [8:0] cur = 9'h0;
    logic [8:0] bus;
    int width = 0, gap = 0, settle_left = 0, need_gap = 0;
    int last_fall_cyc = 0, first_rise_cyc = 0;
    int n_pulses = 0, n_since_rst = 0, n_data_rst = 0;

    // Compare process: every cycle out of reset, check the bus against the model.
    always @(negedge clk) begin
        bus = {lcd_rs, lcd_data};
        if (rst) begin
            prev_e = 1'b0; width = 0; gap = 0; settle_left = 0; need_gap = 0;
            n_since_rst = 0; n_data_rst = 0;
            obs_q.delete();
        end else begin
            chk("rw_low", lcd_rw, 0);
            if (lcd_e) chk("ready_in_pulse", ready, 0);
            if (lcd_e && !prev_e) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got rs=%0d data=%0h, expected no transfer", lcd_rs, lcd_data);
                    cur = bus;
                end else begin
                    cur = exp_q.pop_front();
                    chk("xfer_bus", bus, cur);
                    chk("setup_bus", prev_bus, cur);
                    if (need_gap > 0) chk_ge("gap_low", gap, need_gap);
                end
                if (n_since_rst == 0) first_rise_cyc = cyc;
                obs_q.push_back(bus);
                n_pulses++;
                n_since_rst++;
                if (lcd_rs) n_data_rst++;
                width = 1;
            end else if (lcd_e) begin
                width++;
                chk("pulse_bus", bus, cur);
            end else if (prev_e) begin
                chk("pulse_width", width, P_EP);
                settle_left   = settle_of(cur);
                need_gap      = settle_left + 2;
                gap           = 0;
                last_fall_cyc = cyc;
            end
            if (!lcd_e) begin
                if (settle_left > 0) begin
                    chk("settle_bus", bus, cur);
                    chk("ready_in_settle", ready, 0);
                    settle_left--;
                end
                gap++;
            end
            prev_e   = lcd_e;
            prev_bus = bus;
        end
    end

    int t0 = 0;

    task automatic check_zero(input string tag);
        chk({tag, "_e"}, lcd_e, 0);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_rw"}, lcd_rw, 0);
        chk({tag, "_data"}, lcd_data, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ready"}, ready, 0);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        t0  = cyc;
        @(posedge clk); #1;
        check_zero("post_rst");
    endtask

    task automatic wait_ready(input string name);
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (!full) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("wr_not_full", ok, 1);
        wr_en = 1'b1;
        wr_data = b;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model_byte(b);
    endtask

    task automatic init_check();
        wait_ready("init_ready");
        chk("init_pulses", n_since_rst, 4);
        chk("init_first_rise", first_rise_cyc - t0, 12);
        chk("init_ready_time", cyc - t0, 40);
        chk("clr_settle", cyc - last_fall_cyc, 5);
        chk("init_cmd0", obs_q[0], 9'h038);
        chk("init_cmd1", obs_q[1], 9'h00C);
        chk("init_cmd2", obs_q[2], 9'h006);
        chk("init_cmd3", obs_q[3], 9'h001);
        chk("init_drained", exp_q.size(), 0);
        align();
    endtask

    initial begin
        int np;
        bit seen_e;

        // Power-up: reset held, then a plain init with no writes.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("in_rst");
        release_rst();
        init_check();

        // Single character: SETUP two cycles after wr_en, one data pulse.
        chk("ready_before_wr", ready, 1);
        model_byte(8'h31);
        wr_en = 1'b1; wr_data = 8'h31;
        align();
        wr_en = 1'b0;
        chk("busy_after_wr", ready, 0);
        chk("no_e_yet", lcd_e, 0);
        align();
        chk("setup_e", lcd_e, 0);
        chk("setup_rs", lcd_rs, 1);
        chk("setup_data", lcd_data, 8'h31);
        align();
        chk("pulse_e", lcd_e, 1);
        wait_ready("char_ready");
        chk("char_settle", cyc - last_fall_cyc, 3);
        align();

        // Newline then form feed: 0xC0, then clear with the long settle.
        obs_q.delete();
        wr(8'h0A);
        wr(8'h0C);
        wait_ready("ctl_ready");
        chk("ctl_clr_settle", cyc - last_fall_cyc, 5);
        chk("ctl_count", obs_q.size(), 2);
        chk("ctl_nl", obs_q[0], 9'h0C0);
        chk("ctl_ff", obs_q[1], 9'h001);
        align();
        np = n_pulses;
        wr(8'h00);
        wait_ready("nul_ready");
        repeat (10) align();
        chk("nul_no_xfer", n_pulses, np);
        chk("nul_ready_hold", ready, 1);

        // 17 characters from column 0: line change inserted after the 16th.
        obs_q.delete();
        for (int i = 0; i < 17; i++) wr(8'(8'h41 + i));
        wait_ready("wrap_ready");
        align();
        chk("wrap_count", obs_q.size(), 18);
        chk("wrap_byte16", obs_q[15], 9'h150);
        chk("wrap_cmd", obs_q[16], 9'h0C0);
        chk("wrap_byte17", obs_q[17], 9'h151);
        chk("wrap_drained", exp_q.size(), 0);

        // Six writes during init: four accepted, full after the fourth.
        rst = 1'b1;
        model_reset();
        align();
        check_zero("rst2");
        release_rst();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h61 + i);
            align();
            wr_en = 1'b0;
            if (i < 4) model_byte(8'(8'h61 + i));
            if (i == 2) chk("full_after_3", full, 0);
            if (i == 3) chk("full_after_4", full, 1);
            if (i == 5) chk("full_after_6", full, 1);
        end
        wait_ready("ovf_ready");
        chk("ovf_data_xfers", n_data_rst, 4);
        chk("ovf_total", n_since_rst, 8);
        chk("ovf_drained", exp_q.size(), 0);
        align();

        // Reset during the pulse of a data write: enable drops, init restarts.
        wr(8'h41);
        seen_e = 0;
        for (int i = 0; i < 20; i++) begin
            if (lcd_e) begin
                seen_e = 1;
                break;
            end
            align();
        end
        chk("abort_pulse_seen", seen_e, 1);
        rst = 1'b1;
        model_reset();
        align();
        check_zero("abort_rst");
        release_rst();
        init_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
